// File: rtl/dcache_victim_buffer_pkg.sv
// rtl/dcache_victim_buffer_pkg.sv - shared cache definitions for the dcache victim buffer
package dcache_victim_buffer_pkg;

    localparam int VC_ENTRIES_DEF  = 4;
    localparam int LINE_ADDR_W_DEF = 28;
    localparam int LINE_W_DEF      = 128;

    typedef enum logic {
        VB_IDLE     = 1'b0,
        VB_HIT_PEND = 1'b1
    } type_vbuf_states_e;

    typedef logic [LINE_ADDR_W_DEF-1:0] line_addr_t;
    typedef logic [LINE_W_DEF-1:0]      line_data_t;

endpackage

// File: rtl/vbuf_tag_match.sv
// rtl/vbuf_tag_match.sv - combinational fully-associative tag compare, lowest matching index wins
module vbuf_tag_match #(
    parameter int N = 4,
    parameter int W = 28
) (
    input  logic [N-1:0]         valid_i,
    input  logic [N-1:0][W-1:0]  tags_i,
    input  logic [W-1:0]         addr_i,
    output logic                 hit_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int IW = $clog2(N);

    // Scan downward so the lowest matching index is the last one written.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[i] && (tags_i[i] == addr_i)) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_victim_buffer.sv
// rtl/dcache_victim_buffer.sv - fully-associative clean-line victim buffer for the dcache
// Optional hit/miss counters are enabled by defining VICTIM_BUFFER_STATS_EN.
module dcache_victim_buffer
    import dcache_victim_buffer_pkg::*;
#(
    parameter int VC_ENTRIES  = VC_ENTRIES_DEF,
    parameter int LINE_ADDR_W = LINE_ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lookup_req_i,
    input  logic [LINE_ADDR_W-1:0]        lookup_addr_i,
    output logic                          victim_hit_o,
    output logic [LINE_W-1:0]             hit_data_o,
    input  logic                          write_from_victim_i,
    input  logic                          write_to_victim_i,
    input  logic [LINE_ADDR_W-1:0]        evict_addr_i,
    input  logic [LINE_W-1:0]             evict_data_i,
    input  logic                          flush_i,
    input  logic                          kill_i,
`ifdef VICTIM_BUFFER_STATS_EN
    output logic [31:0]                   hit_cnt_o,
    output logic [31:0]                   miss_cnt_o,
`endif
    output logic [$clog2(VC_ENTRIES):0]   occupancy_o
);

    localparam int IW = $clog2(VC_ENTRIES);
    localparam int OW = IW + 1;

    type_vbuf_states_e                        state_q;
    logic [VC_ENTRIES-1:0]                    valid_q, valid_d;
    logic [VC_ENTRIES-1:0][LINE_ADDR_W-1:0]   tag_q;
    logic [LINE_W-1:0]                        data_q [VC_ENTRIES];
    logic [IW-1:0]                            ptr_q, ptr_d;
    logic [IW-1:0]                            hit_idx_q;
    logic                                     hit_q;
    logic [LINE_W-1:0]                        hit_data_q;
    logic [OW-1:0]                            occ_q, occ_d;

    logic          lk_hit, upd_hit, free_any, consume, ins_en;
    logic [IW-1:0] lk_idx, upd_idx, free_idx, ins_idx;

    vbuf_tag_match #(.N(VC_ENTRIES), .W(LINE_ADDR_W)) u_lookup_match (
        .valid_i (valid_q),
        .tags_i  (tag_q),
        .addr_i  (lookup_addr_i),
        .hit_o   (lk_hit),
        .idx_o   (lk_idx)
    );

    vbuf_tag_match #(.N(VC_ENTRIES), .W(LINE_ADDR_W)) u_insert_match (
        .valid_i (valid_q),
        .tags_i  (tag_q),
        .addr_i  (evict_addr_i),
        .hit_o   (upd_hit),
        .idx_o   (upd_idx)
    );

    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // Slot choice: freed slot on swap, then in-place update, then first hole, then FIFO victim.
    always_comb begin
        consume = (state_q == VB_HIT_PEND) && write_from_victim_i;
        ins_en  = write_to_victim_i && !flush_i;
        ins_idx = ptr_q;
        ptr_d   = ptr_q;
        if (ins_en) begin
            if (consume) begin
                ins_idx = hit_idx_q;
            end else if (upd_hit) begin
                ins_idx = upd_idx;
            end else if (free_any) begin
                ins_idx = free_idx;
            end else begin
                ins_idx = ptr_q;
                ptr_d   = ptr_q + IW'(1);
            end
        end
        valid_d = valid_q;
        if (consume) begin
            valid_d[hit_idx_q] = 1'b0;
        end
        if (ins_en) begin
            valid_d[ins_idx] = 1'b1;
        end
        if (flush_i) begin
            valid_d = '0;
            ptr_d   = '0;
        end
        occ_d = '0;
        for (int i = 0; i < VC_ENTRIES; i++) begin
            occ_d = occ_d + OW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (ins_en) begin
            tag_q[ins_idx]  <= evict_addr_i;
            data_q[ins_idx] <= evict_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= VB_IDLE;
            valid_q    <= '0;
            ptr_q      <= '0;
            hit_idx_q  <= '0;
            hit_q      <= 1'b0;
            hit_data_q <= '0;
            occ_q      <= '0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            if (flush_i) begin
                state_q    <= VB_IDLE;
                hit_q      <= 1'b0;
                hit_data_q <= '0;
            end else begin
                case (state_q)
                    VB_IDLE: begin
                        if (lookup_req_i) begin
                            hit_q     <= lk_hit;
                            hit_idx_q <= lk_idx;
                            if (lk_hit) begin
                                hit_data_q <= data_q[lk_idx];
                                state_q    <= VB_HIT_PEND;
                            end else begin
                                hit_data_q <= '0;
                            end
                        end
                    end
                    VB_HIT_PEND: begin
                        if (write_from_victim_i || kill_i) begin
                            state_q <= VB_IDLE;
                            hit_q   <= 1'b0;
                        end
                    end
                    default: state_q <= VB_IDLE;
                endcase
            end
        end
    end

`ifdef VICTIM_BUFFER_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        lk_fire;

    assign lk_fire = lookup_req_i && (state_q == VB_IDLE) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (lk_fire) begin
            if (lk_hit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!lk_hit && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

    assign victim_hit_o = hit_q;
    assign hit_data_o   = hit_data_q;
    assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_dcache_victim_buffer.sv
// tb/tb_dcache_victim_buffer.sv - directed self-checking bench for dcache_victim_buffer
module tb_dcache_victim_buffer;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          lookup_req_i;
    logic [AW-1:0] lookup_addr_i;
    logic          victim_hit_o;
    logic [DW-1:0] hit_data_o;
    logic          write_from_victim_i;
    logic          write_to_victim_i;
    logic [AW-1:0] evict_addr_i;
    logic [DW-1:0] evict_data_i;
    logic          flush_i;
    logic          kill_i;
    logic [2:0]    occupancy_o;
`ifdef VICTIM_BUFFER_STATS_EN
    logic [31:0]   hit_cnt_o;
    logic [31:0]   miss_cnt_o;
`endif

    int checks = 0;
    int failures = 0;

    dcache_victim_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .lookup_req_i        (lookup_req_i),
        .lookup_addr_i       (lookup_addr_i),
        .victim_hit_o        (victim_hit_o),
        .hit_data_o          (hit_data_o),
        .write_from_victim_i (write_from_victim_i),
        .write_to_victim_i   (write_to_victim_i),
        .evict_addr_i        (evict_addr_i),
        .evict_data_i        (evict_data_i),
        .flush_i             (flush_i),
        .kill_i              (kill_i),
`ifdef VICTIM_BUFFER_STATS_EN
        .hit_cnt_o           (hit_cnt_o),
        .miss_cnt_o          (miss_cnt_o),
`endif
        .occupancy_o         (occupancy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input int n);
        return {4{32'hA5A5_0000 + 32'(n)}};
    endfunction

    task automatic idle_inputs();
        rst = 1'b0; lookup_req_i = 1'b0; lookup_addr_i = '0;
        write_from_victim_i = 1'b0; write_to_victim_i = 1'b0;
        evict_addr_i = '0; evict_data_i = '0; flush_i = 1'b0; kill_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic insert(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_to_victim_i = 1'b1; evict_addr_i = a; evict_data_i = d;
        tick();
        write_to_victim_i = 1'b0;
    endtask

    task automatic lookup(input logic [AW-1:0] a);
        lookup_req_i = 1'b1; lookup_addr_i = a;
        tick();
        lookup_req_i = 1'b0;
    endtask

    task automatic kill();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (victim_hit_o !== 1'b0 || hit_data_o !== '0 || occupancy_o !== 3'd0) begin
            failures++;
            $display("FAIL reset: hit=%b data=%h occ=%0d required 0/0/0", victim_hit_o, hit_data_o, occupancy_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        insert(28'h100, pat(1));
        checks++;
        if (occupancy_o !== 3'd1) begin failures++; $display("FAIL basic_occ1: got %0d required 1", occupancy_o); end
        lookup(28'h100);
        checks++;
        if (victim_hit_o !== 1'b1 || hit_data_o !== pat(1)) begin
            failures++; $display("FAIL basic_hit: hit=%b data=%h required 1/%h", victim_hit_o, hit_data_o, pat(1));
        end
        write_from_victim_i = 1'b1;
        tick();
        write_from_victim_i = 1'b0;
        checks++;
        if (occupancy_o !== 3'd0 || victim_hit_o !== 1'b0) begin
            failures++; $display("FAIL basic_consume: occ=%0d hit=%b required 0/0", occupancy_o, victim_hit_o);
        end
    endtask

    task automatic test_idle_consume();
        do_reset();
        insert(28'h150, pat(2));
        write_from_victim_i = 1'b1;
        tick();
        write_from_victim_i = 1'b0;
        checks++;
        if (occupancy_o !== 3'd1) begin failures++; $display("FAIL idle_consume: occ=%0d required 1", occupancy_o); end
    endtask

    task automatic test_fifo_replace();
        do_reset();
        for (int i = 0; i < 5; i++) insert(28'h200 + 28'(i), pat(10 + i));
        checks++;
        if (occupancy_o !== 3'd4) begin failures++; $display("FAIL fifo_occ: got %0d required 4", occupancy_o); end
        lookup(28'h200);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL fifo_first_miss: hit=%b required 0", victim_hit_o); end
        lookup(28'h204);
        checks++;
        if (victim_hit_o !== 1'b1 || hit_data_o !== pat(14)) begin
            failures++; $display("FAIL fifo_fifth_hit: hit=%b data=%h required 1/%h", victim_hit_o, hit_data_o, pat(14));
        end
        kill();
        checks++;
        if (victim_hit_o !== 1'b0 || occupancy_o !== 3'd4) begin
            failures++; $display("FAIL kill: hit=%b occ=%0d required 0/4", victim_hit_o, occupancy_o);
        end
        lookup(28'h204);
        checks++;
        if (victim_hit_o !== 1'b1) begin failures++; $display("FAIL kill_keeps_entry: hit=%b required 1", victim_hit_o); end
        kill();
        // pointer should now be 1, so the next full insert displaces 0x201
        insert(28'h205, pat(15));
        lookup(28'h201);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL ptr_second_victim: hit=%b required 0", victim_hit_o); end
        lookup(28'h202);
        checks++;
        if (victim_hit_o !== 1'b1 || hit_data_o !== pat(12)) begin
            failures++; $display("FAIL ptr_survivor: hit=%b data=%h required 1/%h", victim_hit_o, hit_data_o, pat(12));
        end
        kill();
    endtask

    task automatic test_swap();
        do_reset();
        insert(28'h300, pat(20));
        insert(28'h301, pat(21));
        lookup(28'h300);
        write_from_victim_i = 1'b1;
        write_to_victim_i = 1'b1; evict_addr_i = 28'h302; evict_data_i = pat(22);
        tick();
        write_from_victim_i = 1'b0; write_to_victim_i = 1'b0;
        checks++;
        if (occupancy_o !== 3'd2 || victim_hit_o !== 1'b0) begin
            failures++; $display("FAIL swap_occ: occ=%0d hit=%b required 2/0", occupancy_o, victim_hit_o);
        end
        lookup(28'h300);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL swap_b_gone: hit=%b required 0", victim_hit_o); end
        lookup(28'h302);
        checks++;
        if (victim_hit_o !== 1'b1 || hit_data_o !== pat(22)) begin
            failures++; $display("FAIL swap_c_present: hit=%b data=%h required 1/%h", victim_hit_o, hit_data_o, pat(22));
        end
        kill();
    endtask

    task automatic test_update();
        do_reset();
        insert(28'h400, pat(30));
        insert(28'h401, pat(31));
        insert(28'h400, pat(32));
        checks++;
        if (occupancy_o !== 3'd2) begin failures++; $display("FAIL update_occ: got %0d required 2", occupancy_o); end
        lookup(28'h400);
        checks++;
        if (victim_hit_o !== 1'b1 || hit_data_o !== pat(32)) begin
            failures++; $display("FAIL update_data: hit=%b data=%h required 1/%h", victim_hit_o, hit_data_o, pat(32));
        end
        kill();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) insert(28'h500 + 28'(i), pat(40 + i));
        checks++;
        if (occupancy_o !== 3'd3) begin failures++; $display("FAIL flush_pre_occ: got %0d required 3", occupancy_o); end
        flush_i = 1'b1;
        write_to_victim_i = 1'b1; evict_addr_i = 28'h503; evict_data_i = pat(43);
        tick();
        flush_i = 1'b0; write_to_victim_i = 1'b0;
        checks++;
        if (occupancy_o !== 3'd0) begin failures++; $display("FAIL flush_occ: got %0d required 0", occupancy_o); end
        lookup(28'h503);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL flush_insert_dropped: hit=%b required 0", victim_hit_o); end
        lookup(28'h500);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL flush_old_gone: hit=%b required 0", victim_hit_o); end
    endtask

    task automatic test_reset_pending();
        do_reset();
        insert(28'h600, pat(50));
        lookup(28'h600);
        checks++;
        if (victim_hit_o !== 1'b1) begin failures++; $display("FAIL rstpend_hit: hit=%b required 1", victim_hit_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (victim_hit_o !== 1'b0 || occupancy_o !== 3'd0 || hit_data_o !== '0) begin
            failures++; $display("FAIL rstpend_clear: hit=%b occ=%0d data=%h required 0/0/0", victim_hit_o, occupancy_o, hit_data_o);
        end
        lookup(28'h600);
        checks++;
        if (victim_hit_o !== 1'b0) begin failures++; $display("FAIL rstpend_miss: hit=%b required 0", victim_hit_o); end
    endtask

`ifdef VICTIM_BUFFER_STATS_EN
    task automatic test_stats();
        do_reset();
        insert(28'h700, pat(60));
        lookup(28'h700);
        kill();
        lookup(28'h701);
        checks++;
        if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
            failures++; $display("FAIL stats_count: hit=%0d miss=%0d required 1/1", hit_cnt_o, miss_cnt_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        checks++;
        if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
            failures++; $display("FAIL stats_flush: hit=%0d miss=%0d required 0/0", hit_cnt_o, miss_cnt_o);
        end
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_idle_consume();
        test_fifo_replace();
        test_swap();
        test_update();
        test_flush();
        test_reset_pending();
`ifdef VICTIM_BUFFER_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_victim_buffer.md
DCACHE_VICTIM_BUFFER -- requirements
Module: dcache_victim_buffer

Interface
REQ-001 Parameter VC_ENTRIES, default 4: number of fully-associative entries; power of two, minimum 2.
REQ-002 Parameter LINE_ADDR_W, default 28: line-address (tag) width.
REQ-003 Parameter LINE_W, default 128: cache-line data width.
REQ-004 clk  in  1  sole clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 lookup_req_i  in  1  probe request, sampled together with the dcache request.
REQ-007 lookup_addr_i  in  LINE_ADDR_W  probe line address.
REQ-008 victim_hit_o  out  1  probe hit, registered.
REQ-009 hit_data_o  out  LINE_W  line data of the hit entry, registered.
REQ-010 write_from_victim_i  in  1  controller consumes the hit line; the entry is invalidated.
REQ-011 write_to_victim_i  in  1  insert the line being evicted from the dcache.
REQ-012 evict_addr_i / evict_data_i  in  LINE_ADDR_W / LINE_W  line to insert.
REQ-013 flush_i  in  1  invalidate all entries.
REQ-014 kill_i  in  1  abort the pending hit.
REQ-015 occupancy_o  out  $clog2(VC_ENTRIES)+1  count of valid entries.

Function
REQ-016 Stored lines are clean, because the dcache writes back dirty lines before handing them over; no write-back path exists.
REQ-017 FSM states: VB_IDLE and VB_HIT_PEND.
REQ-018 Lookup: lookup_req_i=1 at edge N; victim_hit_o and hit_data_o are valid in cycle N+1. The compare uses the valid/tag state as it was before edge N, with no same-cycle insert bypass.
REQ-019 On a hit, latch the matching index and enter VB_HIT_PEND. If more than one entry matches, the lowest index wins.
REQ-020 In VB_HIT_PEND, victim_hit_o and hit_data_o hold until write_from_victim_i or kill_i, then return to VB_IDLE.
REQ-021 write_from_victim_i in VB_HIT_PEND clears the latched entry's valid bit at the next edge.
REQ-022 write_from_victim_i in VB_IDLE is ignored.
REQ-023 write_to_victim_i: if a valid entry already holds evict_addr_i, update it in place. Otherwise write the lowest-index invalid entry. If the buffer is full, replace the entry at the FIFO pointer.
REQ-024 The FIFO pointer advances by 1 modulo VC_ENTRIES on each full replacement only, wrapping from VC_ENTRIES-1 to 0.
REQ-025 Simultaneous write_from_victim_i and write_to_victim_i (swap): the insert goes into the freed slot, occupancy is unchanged, and the pointer is unchanged.
REQ-026 kill_i: return to VB_IDLE and deassert victim_hit_o next cycle; entry state is unchanged.
REQ-027 flush_i: all valid bits cleared, pointer reset to 0, FSM to VB_IDLE at the next edge. flush_i has priority over insert, consume and lookup in the same cycle.
REQ-028 Lookup while in VB_HIT_PEND is ignored; the controller never issues one.
REQ-029 occupancy_o equals the popcount of the valid bits, registered, and never exceeds VC_ENTRIES.

Reset
REQ-030 rst at any edge: valid bits 0, pointer 0, state VB_IDLE, victim_hit_o 0, hit_data_o 0, occupancy_o 0. An operation in progress is dropped.
REQ-031 Tag and data arrays are not reset.

Configuration
REQ-032 Macro VICTIM_BUFFER_STATS_EN.
- Defined: add outputs hit_cnt_o and miss_cnt_o, each 32 bits. They count registered lookup outcomes, saturate at all-ones, and are cleared by rst and by flush_i.
- Undefined: these ports and their counters are absent, and all other behaviour is identical.

Structure
REQ-033 VC_ENTRIES default, the state typedef type_vbuf_states_e, and the line-address/line-data typedefs belong in the shared cache definitions package.
REQ-034 One sub-module, vbuf_tag_match: a combinational match across entries that outputs a hit flag and the lowest matching index.

Verification
REQ-035 Insert A=0x100 into an empty buffer, then lookup 0x100 -> victim_hit_o=1 one cycle later with the data of A; write_from_victim_i -> occupancy_o goes 1 to 0.
REQ-036 Insert 5 distinct lines with VC_ENTRIES=4 -> 5th replaces entry 0; lookup of 1st address misses, 5th hits; pointer=1.
REQ-037 Swap: hit on B, assert write_from_victim_i and write_to_victim_i(C) together -> B gone, C present in B's slot, occupancy_o unchanged.
REQ-038 Insert an already-present address with new data -> occupancy_o unchanged; lookup returns the new data.
REQ-039 flush_i together with write_to_victim_i at occupancy 3 -> occupancy_o=0; the next lookup of the inserted address misses.
REQ-040 rst asserted while in VB_HIT_PEND -> victim_hit_o=0 next cycle; a later lookup of the old address misses.
